// File: rtl/axis_noise_gate.sv
// AXI-Stream stereo noise gate: per-frame peak detector driving a gain ramp FSM.
// Optional status outputs (gate_state, gate_gain) are built when NOISE_GATE_STATUS_EN is defined.
module axis_noise_gate #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned OPEN_TH      = 4096,
  parameter int unsigned CLOSE_TH     = 3072,
  parameter int unsigned HOLD_FRAMES  = 4800,
  parameter int unsigned ATTACK_STEP  = 32,
  parameter int unsigned RELEASE_STEP = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  gate_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last
`ifdef NOISE_GATE_STATUS_EN
  ,
  output logic [2:0]            gate_state,
  output logic [8:0]            gate_gain
`endif
);

  localparam int unsigned SW = SAMPLE_WIDTH;
  localparam int unsigned PW = SAMPLE_WIDTH + 10;
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [8:0]    GAIN_MAX     = 9'd256;
  localparam logic [8:0]    ATTACK_FIRST = (ATTACK_STEP >= 256) ? 9'd256 : 9'(ATTACK_STEP);
  localparam logic [SW-1:0] S_MIN        = {1'b1, {(SW-1){1'b0}}};
  localparam logic [SW-1:0] S_MAX        = {1'b0, {(SW-1){1'b1}}};

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t         state;
  logic [8:0]     gain;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  peak_acc;

  logic                 accept;
  logic [SW-1:0]        x_raw;
  logic signed [SW-1:0] x;
  logic [SW-1:0]        abs_x;
  logic [SW-1:0]        peak;
  logic                 open_hit;
  logic                 close_hit;
  logic [9:0]           up_sum;
  logic [8:0]           gain_up;
  logic [8:0]           gain_dn;
  logic signed [9:0]    gain_s;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] y;
  logic signed [SW-1:0] out_s;

  assign s_axis_ready = ~m_axis_valid | m_axis_ready;
  assign accept       = s_axis_valid & s_axis_ready;
  assign x_raw        = s_axis_data[SW-1:0];
  assign x            = signed'(x_raw);

  // Saturating magnitude: the most negative sample maps to the largest positive one
  always_comb begin
    abs_x = x_raw[SW-1] ? SW'(-x) : x_raw;
    if (x_raw == S_MIN) abs_x = S_MAX;
  end

  assign peak      = (abs_x > peak_acc) ? abs_x : peak_acc;
  assign open_hit  = (peak >= SW'(OPEN_TH));
  assign close_hit = (peak <  SW'(CLOSE_TH));

  assign up_sum  = {1'b0, gain} + 10'(ATTACK_STEP);
  assign gain_up = (up_sum >= 10'd256) ? GAIN_MAX : up_sum[8:0];
  assign gain_dn = (gain <= 9'(RELEASE_STEP)) ? 9'd0 : gain - 9'(RELEASE_STEP);

  // Gain 256 needs a 10-bit signed multiplier operand to stay positive
  assign gain_s = signed'({1'b0, gain});
  assign prod   = PW'(x) * PW'(gain_s);
  assign y      = prod[SW+7:8];
  assign out_s  = gate_enable ? y : x;

  // Single output register stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
    end else if (accept) begin
      m_axis_valid <= 1'b1;
      m_axis_data  <= DATA_WIDTH'(out_s);
      m_axis_last  <= s_axis_last;
    end else if (m_axis_ready) begin
      m_axis_valid <= 1'b0;
    end
  end

  // Gate FSM: advances once per frame on the accepted right-channel word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_CLOSED;
      gain     <= 9'd0;
      hold_cnt <= '0;
      peak_acc <= '0;
    end else if (accept) begin
      peak_acc <= s_axis_last ? '0 : peak;
      if (!gate_enable) begin
        state    <= ST_OPEN;
        gain     <= GAIN_MAX;
        hold_cnt <= '0;
      end else if (s_axis_last) begin
        case (state)
          ST_CLOSED: begin
            gain <= 9'd0;
            if (open_hit) begin
              gain  <= ATTACK_FIRST;
              state <= (ATTACK_FIRST == GAIN_MAX) ? ST_OPEN : ST_ATTACK;
            end
          end
          ST_ATTACK: begin
            gain <= gain_up;
            if (gain_up == GAIN_MAX) state <= ST_OPEN;
          end
          ST_OPEN: begin
            gain <= GAIN_MAX;
            if (close_hit) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
          ST_HOLD: begin
            if (open_hit) begin
              state <= ST_OPEN;
            end else if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
              gain  <= gain_dn;
              state <= (gain_dn == 9'd0) ? ST_CLOSED : ST_RELEASE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          ST_RELEASE: begin
            if (open_hit) begin
              state <= ST_ATTACK;
            end else begin
              gain <= gain_dn;
              if (gain_dn == 9'd0) state <= ST_CLOSED;
            end
          end
          default: begin
            state <= ST_CLOSED;
            gain  <= 9'd0;
          end
        endcase
      end
    end
  end

  logic unused_prod;
  assign unused_prod = ^{prod[PW-1:SW+8], prod[7:0]};

  generate
    if (DATA_WIDTH > SAMPLE_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^s_axis_data[DATA_WIDTH-1:SAMPLE_WIDTH];
    end
  endgenerate

`ifdef NOISE_GATE_STATUS_EN
  assign gate_state = state;
  assign gate_gain  = gain;
`else
  // Status taps not built; datapath unchanged
`endif

endmodule

// File: tb/tb_axis_noise_gate.sv
// Bench for axis_noise_gate: directed frames, expected words queued at accept,
// popped and compared by an independent output monitor.
module tb_axis_noise_gate;

  logic        clk = 1'b0;
  logic        resetn;
  logic        gate_enable;
  logic [31:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        s_axis_last;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;
`ifdef NOISE_GATE_STATUS_EN
  logic [2:0]  gate_state;
  logic [8:0]  gate_gain;
`endif

  axis_noise_gate #(
    .DATA_WIDTH(32), .SAMPLE_WIDTH(24), .OPEN_TH(4096), .CLOSE_TH(3072),
    .HOLD_FRAMES(4), .ATTACK_STEP(32), .RELEASE_STEP(64)
  ) dut (
    .clk(clk), .resetn(resetn), .gate_enable(gate_enable),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last)
`ifdef NOISE_GATE_STATUS_EN
    , .gate_state(gate_state), .gate_gain(gate_gain)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] held;
  bit          held_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops one expectation per handshake, checks stall behaviour
  always @(negedge clk) begin
    if (!resetn) begin
      held_v = 1'b0;
    end else if (m_axis_valid && m_axis_ready) begin
      held_v = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {31'd0, m_axis_last, m_axis_data}, 64'hDEAD);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("out_word", {31'd0, m_axis_last, m_axis_data}, {31'd0, e});
      end
    end else if (m_axis_valid) begin
      chk("stall_s_ready", {63'd0, s_axis_ready}, 64'd0);
      if (held_v) chk("stall_hold", {31'd0, m_axis_last, m_axis_data}, {31'd0, held});
      held   = {m_axis_last, m_axis_data};
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic last, input logic [31:0] exp);
    int n;
    logic rdy;
    s_axis_data  = d;
    s_axis_last  = last;
    s_axis_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_axis_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) chk("send_timeout", 64'd0, 64'd1);
    else exp_q.push_back({last, exp});
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] el, input logic [31:0] er);
    send(l, 1'b0, el);
    send(r, 1'b1, er);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input logic [2:0] st, input logic [8:0] g);
`ifdef NOISE_GATE_STATUS_EN
    chk("gate_state", 64'(gate_state), 64'(st));
    chk("gate_gain", 64'(gate_gain), 64'(g));
`else
    if (st === 3'bx || g === 9'bx) $display("status unused");
`endif
  endtask

  initial begin
    resetn       = 1'b0;
    gate_enable  = 1'b1;
    s_axis_data  = '0;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    m_axis_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_data", 64'(m_axis_data), 64'd0);
    chk("rst_last", 64'(m_axis_last), 64'd0);
    chk_status(3'd0, 9'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Quiet frames stay muted
    frame(32'd100, 32'd100, 32'd0, 32'd0);
    frame(32'd100, 32'd100, 32'd0, 32'd0);

    // Attack ramp 0, 0x2000 .. 0x10000
    for (int k = 0; k <= 8; k++)
      frame(32'h010000, 32'h010000, 32'(k * 32'h2000), 32'(k * 32'h2000));
    drain();
    chk_status(3'd2, 9'd256);

    // Fully open: sign extension, upper input bits ignored
    frame(32'hABFFEC78, 32'h5A001388, 32'hFFFFEC78, 32'h00001388);

    // Hold for 4 frames at full gain, then release in steps of 64
    for (int k = 0; k < 5; k++) frame(32'd1000, 32'h00FFFC18, 32'd1000, 32'hFFFFFC18);
    frame(32'd1000, 32'h00FFFC18, 32'd750, 32'hFFFFFD12);
    frame(32'd1000, 32'h00FFFC18, 32'd500, 32'hFFFFFE0C);
    frame(32'd1001, 32'h00FFFC17, 32'd250, 32'hFFFFFF05);
    frame(32'd1000, 32'h00FFFC18, 32'd0, 32'd0);
    drain();
    chk_status(3'd0, 9'd0);

    // Threshold boundary: 4095 stays closed, 4096 opens
    frame(32'd4095, 32'h00FFF001, 32'd0, 32'd0);
    frame(32'd4096, 32'd0, 32'd0, 32'd0);
    frame(32'd4096, 32'h00FFF000, 32'd512, 32'hFFFFFE00);

    // Downstream stall for 5 cycles
    m_axis_ready = 1'b0;
    fork
      frame(32'd4096, 32'd4096, 32'd1024, 32'd1024);
      begin
        repeat (5) @(posedge clk);
        #1;
        m_axis_ready = 1'b1;
      end
    join
    drain();
    chk_status(3'd1, 9'd96);

    // Reset mid-frame during attack
    send(32'h010000, 1'b0, 32'h6000);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(m_axis_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    frame(32'h010000, 32'h010000, 32'd0, 32'd0);
    drain();

    // Bypass passes extremes through, then re-enable starts open
    gate_enable = 1'b0;
    send(32'h00800000, 1'b0, 32'hFF800000);
    send(32'h007FFFFF, 1'b1, 32'h007FFFFF);
    drain();
    chk_status(3'd2, 9'd256);
    gate_enable = 1'b1;
    frame(32'd100, 32'd100, 32'd100, 32'd100);
    drain();
    chk_status(3'd3, 9'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
